// File: rtl/mem_arbiter_2p.sv
// rtl/mem_arbiter_2p.sv - two-port round-robin arbiter and access sequencer for a single-port RAM
//
// Ports A and B present valid/ready requests (req_*_x). The winner is latched onto the
// RAM command port (mem_valid/mem_wrd/mem_addr/mem_wdata) for one cycle. The arbiter then
// waits for mem_ready and returns a one-cycle response (rsp_valid_x/rsp_rdata_x/rsp_err_x)
// to the port that owned the access. If mem_ready never arrives within TIMEOUT cycles, a
// watchdog ends the access with rsp_err_x=1.
//   clk, rst            : clock, synchronous active-high reset
//   req_*_a / req_*_b   : request channels (valid, ready, wrd, addr, wdata)
//   rsp_*_a / rsp_*_b   : response pulses (valid, rdata, err)
//   mem_*               : RAM command outputs and ready/rdata inputs
module mem_arbiter_2p #(
  parameter int W       = 8,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_a,
  output logic              req_ready_a,
  input  logic              req_wrd_a,
  input  logic [ADDR_W-1:0] req_addr_a,
  input  logic [W-1:0]      req_wdata_a,
  output logic              rsp_valid_a,
  output logic [W-1:0]      rsp_rdata_a,
  output logic              rsp_err_a,
  input  logic              req_valid_b,
  output logic              req_ready_b,
  input  logic              req_wrd_b,
  input  logic [ADDR_W-1:0] req_addr_b,
  input  logic [W-1:0]      req_wdata_b,
  output logic              rsp_valid_b,
  output logic [W-1:0]      rsp_rdata_b,
  output logic              rsp_err_b,
  output logic              mem_valid,
  output logic              mem_wrd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [W-1:0]      mem_wdata,
  input  logic              mem_ready,
  input  logic [W-1:0]      mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  // Watchdog fires on the WAIT cycle in which the counter would reach TIMEOUT.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       last;   // port served most recently: 0 = A, 1 = B
  logic       owner;  // port owning the access in flight: 0 = A, 1 = B
  logic [7:0] cnt;
  logic       win_b;
  logic       done;
  logic [W-1:0] rsp_data;

  // B wins when it is the only requester, or both request and A was served last.
  always_comb begin
    win_b       = req_valid_b && (!req_valid_a || !last);
    req_ready_a = (state == IDLE) && !win_b && req_valid_a && !rst;
    req_ready_b = (state == IDLE) && win_b && req_valid_b && !rst;
  end

  always_comb begin
    done     = mem_ready || (cnt == CNT_LAST);
    rsp_data = (mem_ready && !mem_wrd) ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last        <= 1'b1;
      owner       <= 1'b0;
      cnt         <= '0;
      mem_valid   <= 1'b0;
      mem_wrd     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rsp_valid_a <= 1'b0;
      rsp_rdata_a <= '0;
      rsp_err_a   <= 1'b0;
      rsp_valid_b <= 1'b0;
      rsp_rdata_b <= '0;
      rsp_err_b   <= 1'b0;
    end else begin
      // Responses are single-cycle pulses; everything drops back to 0 by default.
      rsp_valid_a <= 1'b0;
      rsp_rdata_a <= '0;
      rsp_err_a   <= 1'b0;
      rsp_valid_b <= 1'b0;
      rsp_rdata_b <= '0;
      rsp_err_b   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_ready_a || req_ready_b) begin
            mem_wrd   <= win_b ? req_wrd_b   : req_wrd_a;
            mem_addr  <= win_b ? req_addr_b  : req_addr_a;
            mem_wdata <= win_b ? req_wdata_b : req_wdata_a;
            owner     <= win_b;
            mem_valid <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_valid <= 1'b0;
          cnt       <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (done) begin
            if (owner) begin
              rsp_valid_b <= 1'b1;
              rsp_rdata_b <= rsp_data;
              rsp_err_b   <= !mem_ready;
            end else begin
              rsp_valid_a <= 1'b1;
              rsp_rdata_a <= rsp_data;
              rsp_err_a   <= !mem_ready;
            end
            last  <= owner;
            state <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
